progc_pipe: RTL and testbench
=============================

Name: progc_pipe

Overview:
Parametrised program-counter unit for the pipelined RISC-V core. It generates fetch addresses under a valid/ready handshake with instruction memory and applies branch/JAL/JALR redirects resolved later in the pipeline. It holds the PC across hazard stalls and latches any redirect that arrives during a stall. It also supports halt/resume and a trap vector, and outputs a link value and an accepted-fetch counter.

Parameters:
N, 32, address width; all address arithmetic is modulo 2^N.
STEP, 1, sequential increment (1 = word addressing, 4 = byte addressing).
RESET_VEC, 0, PC value loaded by reset.
TRAP_VEC, 'h10, PC value loaded on trap.
CNT_W, 16, width of the accepted-fetch counter.

Ports:
clock  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-low reset; sampled on posedge clock; reset==0 resets the block.
pcsel  in  2  redirect type: 00 none, 01 JALR (tgt=targaddr), 10 branch (tgt=basepc+targaddr), 11 JAL (tgt=basepc+targaddr).
basepc  in  N  PC of the instruction producing the redirect.
targaddr  in  N  offset (10/11) or absolute target (01).
stall  in  1  hazard-unit stall; holds the PC.
halt  in  1  request to stop fetching.
resume  in  1  leave HALT.
trap  in  1  trap request; highest priority.
fready  in  1  instruction memory accepts the current fetch.
pcOut  out  N  current fetch address.
fvalid  out  1  pcOut is a valid fetch request.
pcplus4  out  N  link value (basepc+STEP), registered on 01/11 redirects.
flush  out  1  one-cycle pulse, high in the cycle pcOut first shows a redirect or trap target.
pend  out  1  a latched redirect is waiting.
fcount  out  CNT_W  number of accepted fetches (fvalid&&fready).

Behaviour:
- Reset (reset==0 at posedge):
  - pcOut=RESET_VEC, pcplus4=0, flush=0, pend=0, fcount=0, state=BOOT.
  - Reset overrides every other input, including mid-stall, mid-halt and with a pending redirect.
- States: BOOT, RUN, HALT.
  - BOOT: fvalid=0. Moves unconditionally to RUN after one cycle; other inputs are ignored in BOOT.
  - RUN: fvalid = !stall.
  - HALT: fvalid=0; pcOut is held.
- Target and link computation:
  - Target is computed at the cycle pcsel!=00 is sampled, using that cycle's basepc/targaddr.
  - On 01/11, pcplus4<=basepc+STEP in the same edge; it is held otherwise.
- RUN next-PC priority, per edge:
  1. trap: pcOut<=TRAP_VEC, pend<=0, flush<=1.
  2. pcsel!=00 and !stall: pcOut<=target, flush<=1, pend<=0. This replaces an unaccepted fetch regardless of fready.
  3. pcsel!=00 and stall: pending target register <= target, pend<=1, pcOut held.
  4. pend and !stall: pcOut<=pending target, pend<=0, flush<=1.
  5. fvalid&&fready: pcOut<=pcOut+STEP.
  6. Otherwise pcOut is held; flush<=0 whenever rules 1, 2 and 4 do not fire.
- A second redirect while pend=1 overwrites the pending target (newest wins).
- halt in RUN:
  - Enters HALT at the next edge.
  - If fvalid&&fready in that same cycle, the increment still happens.
  - Redirect/trap in that cycle is applied per priority; the state still becomes HALT, except trap, which keeps RUN.
- HALT:
  - pcsel!=00 latches into pend/pending target.
  - trap: pcOut<=TRAP_VEC, pend<=0, flush<=1, ->RUN.
  - resume: ->RUN; a held pend is then applied by rule 4 in RUN.
  - halt and resume both high: resume wins.
- Wrap-around: pcOut+STEP and basepc+targaddr wrap modulo 2^N with no error flag. A negative offset is the two's-complement targaddr.
- fcount increments on each fvalid&&fready and saturates at 2^CNT_W-1.
- Handshake: while fvalid=1 and fready=0, pcOut stays stable unless trap or an unstalled redirect fires.

Test Plan:
1. Reset and sequential fetch. Reset low 2 cycles, then high, fready=1, STEP=1. Required: BOOT cycle with fvalid=0, then pcOut 0,1,2,3 and fcount=3 after 3 accepts. With fready=0 for 2 cycles, pcOut holds at 3.
2. Branch and JAL. At pcOut=5, pcsel=10, basepc=3, targaddr=-2. Required: next pcOut=1, flush pulse one cycle. Then pcsel=11, basepc=8, targaddr=4: pcOut=12, pcplus4=9.
3. Redirect under stall. stall=1, pcsel=01, targaddr=40 for one cycle; stall held 3 more cycles. Required: pcOut held, pend=1, fvalid=0. On stall release, pcOut=40 and flush=1 in the same cycle, then pend=0.
4. Trap priority. trap=1 with pcsel=11 and pend=1 in the same cycle. Required: pcOut=TRAP_VEC ('h10), pend=0, pcplus4 updated per the 11 link.
5. Halt/resume. halt at pcOut=7 with fready=1. Required: pcOut=8, HALT, fvalid=0. Redirect to 20 during HALT sets pend=1. resume gives RUN, then pcOut=20 with flush.
6. Wrap and mid-operation reset. N=8, pcOut=255, accept gives pcOut=0. Reset asserted while pend=1 in HALT: pcOut=RESET_VEC, pend=0, state BOOT.

Source files
------------

// File: rtl/progc_pipe_if.sv
// Fetch handshake between the program-counter unit (master) and instruction memory (slave).
// N must match the N of the progc_pipe instance that drives it.
interface progc_pipe_if #(
    parameter int N = 32
);
    logic [N-1:0] pcOut;
    logic         fvalid;
    logic         fready;

    modport master (output pcOut, output fvalid, input fready);
    modport slave  (input pcOut, input fvalid, output fready);
endinterface

// File: rtl/progc_pipe.sv
// Program-counter unit: sequential fetch under valid/ready, branch/JAL/JALR redirects,
// stall-time redirect latching, halt/resume, trap vector, link value and fetch counter.
module progc_pipe #(
    parameter int             N         = 32,
    parameter int             STEP      = 1,
    parameter logic [N-1:0]   RESET_VEC = '0,
    parameter logic [N-1:0]   TRAP_VEC  = 'h10,
    parameter int             CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    progc_pipe_if.master     fbus,
    input  logic [1:0]       pcsel,
    input  logic [N-1:0]     basepc,
    input  logic [N-1:0]     targaddr,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             trap,
    output logic [N-1:0]     pcplus4,
    output logic             flush,
    output logic             pend,
    output logic [CNT_W-1:0] fcount
);
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [N-1:0] STEP_N = N'(STEP);

    logic [1:0]   state;
    logic [N-1:0] pc;
    logic [N-1:0] pend_tgt;
    logic [N-1:0] target;
    logic         redirect;
    logic         fvalid;
    logic         accept;

    // JALR takes an absolute target; branch and JAL are basepc-relative (wrapping).
    assign redirect = (pcsel != 2'b00);
    assign target   = (pcsel == 2'b01) ? targaddr : basepc + targaddr;
    assign fvalid   = (state == ST_RUN) && !stall;
    assign accept   = fvalid && fbus.fready;

    assign fbus.pcOut  = pc;
    assign fbus.fvalid = fvalid;

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values;
    // flush defaults low first and the redirect branches override it.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= ST_BOOT;
            pc       <= RESET_VEC;
            pend_tgt <= '0;
            pcplus4  <= '0;
            flush    <= 1'b0;
            pend     <= 1'b0;
            fcount   <= '0;
        end else begin
            flush <= 1'b0;
            if (accept && (fcount != {CNT_W{1'b1}}))
                fcount <= fcount + CNT_W'(1);

            case (state)
                ST_BOOT: state <= ST_RUN;

                ST_RUN: begin
                    if (pcsel[0])
                        pcplus4 <= basepc + STEP_N;
                    state <= (halt && !trap) ? ST_HALT : ST_RUN;
                    if (trap) begin
                        pc    <= TRAP_VEC;
                        pend  <= 1'b0;
                        flush <= 1'b1;
                    end else if (redirect && !stall) begin
                        pc    <= target;
                        pend  <= 1'b0;
                        flush <= 1'b1;
                    end else if (redirect) begin
                        pend_tgt <= target;
                        pend     <= 1'b1;
                    end else if (pend && !stall) begin
                        pc    <= pend_tgt;
                        pend  <= 1'b0;
                        flush <= 1'b1;
                    end else if (accept) begin
                        pc <= pc + STEP_N;
                    end
                end

                ST_HALT: begin
                    if (pcsel[0])
                        pcplus4 <= basepc + STEP_N;
                    if (trap) begin
                        pc    <= TRAP_VEC;
                        pend  <= 1'b0;
                        flush <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        // A redirect seen while halted waits in pend until RUN resumes.
                        if (redirect) begin
                            pend_tgt <= target;
                            pend     <= 1'b1;
                        end
                        if (resume)
                            state <= ST_RUN;
                    end
                end

                default: state <= ST_BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_progc_pipe.sv
// Self-checking bench for progc_pipe: directed test-plan sequences followed by random
// stimulus, every cycle compared against a behavioural model of the PC unit.
module tb_progc_pipe;
    localparam int          N      = 8;
    localparam int          STEP   = 1;
    localparam int          CNT_W  = 6;
    localparam int unsigned MOD    = 1 << N;
    localparam int unsigned CMAX   = (1 << CNT_W) - 1;
    localparam int unsigned RVEC   = 0;
    localparam int unsigned TVEC   = 'h10;

    logic             clock = 1'b0;
    logic             reset;
    logic [1:0]       pcsel;
    logic [N-1:0]     basepc;
    logic [N-1:0]     targaddr;
    logic             stall;
    logic             halt;
    logic             resume;
    logic             trap;
    logic [N-1:0]     pcplus4;
    logic             flush;
    logic             pend;
    logic [CNT_W-1:0] fcount;

    progc_pipe_if #(.N(N)) fbus ();

    progc_pipe #(
        .N(N), .STEP(STEP), .RESET_VEC(N'(RVEC)), .TRAP_VEC(N'(TVEC)), .CNT_W(CNT_W)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .fbus     (fbus.master),
        .pcsel    (pcsel),
        .basepc   (basepc),
        .targaddr (targaddr),
        .stall    (stall),
        .halt     (halt),
        .resume   (resume),
        .trap     (trap),
        .pcplus4  (pcplus4),
        .flush    (flush),
        .pend     (pend),
        .fcount   (fcount)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: integer arithmetic modulo 2^N, one mode per architectural state.
    typedef enum int {M_BOOT, M_RUN, M_HALT} mode_t;
    mode_t       m_mode;
    int unsigned m_pc, m_tgt, m_link, m_cnt;
    bit          m_flush, m_pend;

    function automatic int unsigned wrap(input int unsigned v);
        return v % MOD;
    endfunction

    task automatic model_step();
        int unsigned dest;
        bit          fetch_ok;
        if (!reset) begin
            m_mode = M_BOOT; m_pc = RVEC; m_tgt = 0; m_link = 0;
            m_cnt = 0; m_flush = 0; m_pend = 0;
            return;
        end
        m_flush = 0;
        if (m_mode == M_BOOT) begin
            m_mode = M_RUN;
            return;
        end
        dest     = (pcsel == 2'b01) ? int'(targaddr) : wrap(int'(basepc) + int'(targaddr));
        fetch_ok = (m_mode == M_RUN) && !stall && fbus.fready;
        if (fetch_ok && m_cnt < CMAX) m_cnt++;
        if (pcsel == 2'b01 || pcsel == 2'b11) m_link = wrap(int'(basepc) + STEP);

        if (trap) begin
            m_pc = TVEC; m_pend = 0; m_flush = 1; m_mode = M_RUN;
        end else if (m_mode == M_HALT) begin
            if (pcsel != 0) begin m_tgt = dest; m_pend = 1; end
            if (resume) m_mode = M_RUN;
        end else begin
            if (pcsel != 0 && !stall) begin
                m_pc = dest; m_pend = 0; m_flush = 1;
            end else if (pcsel != 0) begin
                m_tgt = dest; m_pend = 1;
            end else if (m_pend && !stall) begin
                m_pc = m_tgt; m_pend = 0; m_flush = 1;
            end else if (fetch_ok) begin
                m_pc = wrap(m_pc + STEP);
            end
            if (halt) m_mode = M_HALT;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check("pcOut",   32'(fbus.pcOut), m_pc);
        check("fvalid",  32'(fbus.fvalid), 32'((m_mode == M_RUN) && !stall));
        check("pcplus4", 32'(pcplus4), m_link);
        check("flush",   32'(flush), 32'(m_flush));
        check("pend",    32'(pend), 32'(m_pend));
        check("fcount",  32'(fcount), m_cnt);
    endtask

    task automatic idle_inputs();
        reset = 1'b1; pcsel = 2'b00; basepc = '0; targaddr = '0;
        stall = 1'b0; halt = 1'b0; resume = 1'b0; trap = 1'b0; fbus.fready = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;

        // 1. Reset and sequential fetch
        tick(); tick();
        check("rst_pc", 32'(fbus.pcOut), RVEC);
        reset = 1'b1;
        check("boot_fvalid", 32'(fbus.fvalid), 0);
        tick();
        check("run_pc0", 32'(fbus.pcOut), 0);
        tick(); tick(); tick();
        check("seq_pc3", 32'(fbus.pcOut), 3);
        check("seq_cnt3", 32'(fcount), 3);
        fbus.fready = 1'b0;
        tick(); tick();
        check("hold_pc3", 32'(fbus.pcOut), 3);
        fbus.fready = 1'b1;
        tick(); tick();

        // 2. Branch with negative offset, then JAL with link
        check("pc_at5", 32'(fbus.pcOut), 5);
        pcsel = 2'b10; basepc = 8'd3; targaddr = 8'hFE;
        tick();
        check("br_pc", 32'(fbus.pcOut), 1);
        check("br_flush", 32'(flush), 1);
        pcsel = 2'b11; basepc = 8'd8; targaddr = 8'd4;
        tick();
        check("jal_pc", 32'(fbus.pcOut), 12);
        check("jal_link", 32'(pcplus4), 9);
        pcsel = 2'b00;
        tick();
        check("flush_drop", 32'(flush), 0);

        // 3. Redirect under stall
        stall = 1'b1; pcsel = 2'b01; targaddr = 8'd40;
        tick();
        pcsel = 2'b00;
        tick(); tick(); tick();
        check("stall_pend", 32'(pend), 1);
        check("stall_fvalid", 32'(fbus.fvalid), 0);
        check("stall_pc", 32'(fbus.pcOut), 13);
        stall = 1'b0;
        tick();
        check("rel_pc", 32'(fbus.pcOut), 40);
        check("rel_flush", 32'(flush), 1);
        check("rel_pend", 32'(pend), 0);

        // 4. Trap beats JAL and a pending redirect
        stall = 1'b1; pcsel = 2'b01; targaddr = 8'd50;
        tick();
        trap = 1'b1; pcsel = 2'b11; basepc = 8'd20; targaddr = 8'd3;
        tick();
        check("trap_pc", 32'(fbus.pcOut), TVEC);
        check("trap_pend", 32'(pend), 0);
        check("trap_link", 32'(pcplus4), 21);
        idle_inputs();

        // 5. Halt, redirect while halted, resume
        pcsel = 2'b01; targaddr = 8'd7;
        tick();
        pcsel = 2'b00; halt = 1'b1;
        tick();
        check("halt_pc", 32'(fbus.pcOut), 8);
        check("halt_fvalid", 32'(fbus.fvalid), 0);
        halt = 1'b0; pcsel = 2'b01; targaddr = 8'd20;
        tick();
        check("halt_pend", 32'(pend), 1);
        pcsel = 2'b00; halt = 1'b1; resume = 1'b1;
        tick();
        check("resume_fvalid", 32'(fbus.fvalid), 1);
        halt = 1'b0; resume = 1'b0;
        tick();
        check("resume_pc", 32'(fbus.pcOut), 20);
        check("resume_flush", 32'(flush), 1);

        // 6. Wrap-around, then reset while halted with a pending redirect
        pcsel = 2'b01; targaddr = 8'd255;
        tick();
        pcsel = 2'b00;
        tick();
        check("wrap_pc", 32'(fbus.pcOut), 0);
        halt = 1'b1;
        tick();
        halt = 1'b0; pcsel = 2'b01; targaddr = 8'd30;
        tick();
        check("pre_rst_pend", 32'(pend), 1);
        pcsel = 2'b00; reset = 1'b0; stall = 1'b1;
        tick();
        check("mid_rst_pc", 32'(fbus.pcOut), RVEC);
        check("mid_rst_pend", 32'(pend), 0);
        idle_inputs();
        check("mid_rst_boot", 32'(fbus.fvalid), 0);

        // Counter saturation
        for (int i = 0; i < 70; i++) tick();
        check("cnt_sat", 32'(fcount), CMAX);

        // Random stimulus
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) != 0);
            trap        = ($urandom_range(0, 39) == 0);
            halt        = ($urandom_range(0, 19) == 0);
            resume      = ($urandom_range(0, 3) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            fbus.fready = ($urandom_range(0, 3) != 0);
            pcsel       = ($urandom_range(0, 9) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
            basepc      = N'($urandom);
            targaddr    = N'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
